// File: rtl/dac_frame_sequencer_if.sv
// DAC driver handshake bundle between the frame sequencer and the DAC70004 serial driver.
//   DAC_WE    one-cycle frame strobe, sequencer -> driver
//   DAC_DATA  32-bit frame, sequencer -> driver
//   DAC_BUSY  frame in progress, driver -> sequencer
// master: sequencer side; slave: driver side.
interface dac_frame_sequencer_if;
    logic        DAC_WE;
    logic [31:0] DAC_DATA;
    logic        DAC_BUSY;

    modport master (
        output DAC_WE,
        output DAC_DATA,
        input  DAC_BUSY
    );

    modport slave (
        input  DAC_WE,
        input  DAC_DATA,
        output DAC_BUSY
    );
endinterface

// File: rtl/dac_frame_sequencer.sv
// Upstream command stage for the DAC70004 serial driver.
// Keeps a 16-bit shadow code and a dirty flag per channel (4 channels) and sends
// write-and-update frames {4'b0, CMD_WR_UPD, 2'b00, ch, code, 4'b0} one at a time over
// the DAC_WE / DAC_DATA / DAC_BUSY handshake, lowest dirty channel first.
//
// Ports:
//   CLK_50M      system clock, rising edge
//   RST          synchronous active-high reset
//   CH_WE/CH_ADDR/CH_DATA  shadow write (sets the channel dirty)
//   UPDATE       pulse, arms a flush of all dirty channels
//   AUTO_UPDATE  level, send dirty channels without UPDATE
//   REFRESH_ALL  pulse, marks all channels dirty
//   dac          driver handshake (master modport)
//   SEQ_BUSY     not idle, or a flush is armed
//   DIRTY        per-channel dirty flags
//   FRAME_CNT    frames issued (wrapping)
//   TIMEOUT_ERR  sticky: driver never raised DAC_BUSY after a strobe
//
// Build option: define DAC_SEQ_INIT_EN to send INIT_FRAME once after every reset
// before normal operation.
module dac_frame_sequencer #(
    parameter logic [3:0]  CMD_WR_UPD   = 4'h3,
`ifdef DAC_SEQ_INIT_EN
    parameter logic [31:0] INIT_FRAME   = 32'h0900_0000,
`endif
    parameter int unsigned BUSY_TIMEOUT = 255
) (
    input  logic                         CLK_50M,
    input  logic                         RST,
    input  logic                         CH_WE,
    input  logic [1:0]                   CH_ADDR,
    input  logic [15:0]                  CH_DATA,
    input  logic                         UPDATE,
    input  logic                         AUTO_UPDATE,
    input  logic                         REFRESH_ALL,
    dac_frame_sequencer_if.master        dac,
    output logic                         SEQ_BUSY,
    output logic [3:0]                   DIRTY,
    output logic [15:0]                  FRAME_CNT,
    output logic                         TIMEOUT_ERR
);

    // Counter only has to reach BUSY_TIMEOUT-1.
    localparam int unsigned WaitW = (BUSY_TIMEOUT > 1) ? $clog2(BUSY_TIMEOUT) : 1;

    typedef enum logic [2:0] {
`ifdef DAC_SEQ_INIT_EN
        StInit,
`endif
        StIdle,
        StIssue,
        StWaitHi,
        StWaitLo
    } state_e;

`ifdef DAC_SEQ_INIT_EN
    localparam state_e RstState = StInit;
`else
    localparam state_e RstState = StIdle;
`endif

    state_e             state_q, state_d;
    logic [15:0]        shadow_q [4];
    logic [15:0]        shadow_d [4];
    logic [3:0]         dirty_q, dirty_d;
    logic               flush_q, flush_d;
    logic [1:0]         ch_q, ch_d;
    logic               dac_we_q, dac_we_d;
    logic [31:0]        dac_data_q, dac_data_d;
    logic [15:0]        frame_cnt_q, frame_cnt_d;
    logic               timeout_q, timeout_d;
    logic [WaitW-1:0]   wait_cnt_q, wait_cnt_d;
    logic               seq_busy_q, seq_busy_d;
    logic [1:0]         low_ch;
    logic               issue_init;
`ifdef DAC_SEQ_INIT_EN
    logic               is_init_q, is_init_d;
`endif

    // Lowest-index dirty channel.
    always_comb begin
        low_ch = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (dirty_q[i]) low_ch = 2'(i);
        end
    end

`ifdef DAC_SEQ_INIT_EN
    assign issue_init = is_init_q;
`else
    assign issue_init = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        shadow_d    = shadow_q;
        dirty_d     = dirty_q;
        flush_d     = flush_q;
        ch_d        = ch_q;
        dac_we_d    = 1'b0;
        dac_data_d  = dac_data_q;
        frame_cnt_d = frame_cnt_q;
        timeout_d   = timeout_q;
        wait_cnt_d  = wait_cnt_q;
`ifdef DAC_SEQ_INIT_EN
        is_init_d   = is_init_q;
`endif

        unique case (state_q)
`ifdef DAC_SEQ_INIT_EN
            StInit: begin
                if (!dac.DAC_BUSY) begin
                    state_d   = StIssue;
                    is_init_d = 1'b1;
                end
            end
`endif
            StIdle: begin
                if ((dirty_q != 4'd0) && !dac.DAC_BUSY && (flush_q || AUTO_UPDATE)) begin
                    state_d = StIssue;
                    ch_d    = low_ch;
                end
            end
            StIssue: begin
                dac_we_d    = 1'b1;
                dac_data_d  = {4'b0, CMD_WR_UPD, 2'b00, ch_q, shadow_q[ch_q], 4'b0};
                frame_cnt_d = frame_cnt_q + 16'd1;
                wait_cnt_d  = '0;
                state_d     = StWaitHi;
                if (!issue_init) dirty_d[ch_q] = 1'b0;
`ifdef DAC_SEQ_INIT_EN
                if (is_init_q) dac_data_d = INIT_FRAME;
                is_init_d = 1'b0;
`endif
            end
            StWaitHi: begin
                if (dac.DAC_BUSY) begin
                    state_d = StWaitLo;
                end else if (wait_cnt_q == WaitW'(BUSY_TIMEOUT - 1)) begin
                    // Frame is dropped; the channel is deliberately not re-marked dirty.
                    timeout_d = 1'b1;
                    state_d   = StIdle;
                end else begin
                    wait_cnt_d = wait_cnt_q + 1'b1;
                end
            end
            StWaitLo: begin
                if (!dac.DAC_BUSY) state_d = StIdle;
            end
            default: state_d = RstState;
        endcase

        // Applied after the ISSUE clear so a same-cycle write to that channel wins.
        if (REFRESH_ALL) dirty_d = 4'hF;
        if (CH_WE) begin
            shadow_d[CH_ADDR] = CH_DATA;
            dirty_d[CH_ADDR]  = 1'b1;
        end

        if ((state_q == StIdle) && (dirty_q == 4'd0)) flush_d = 1'b0;
        if (UPDATE) flush_d = 1'b1;

        seq_busy_d = (state_d != StIdle) || flush_d;
    end

    always_ff @(posedge CLK_50M) begin
        if (RST) begin
            state_q     <= RstState;
            for (int i = 0; i < 4; i++) shadow_q[i] <= '0;
            dirty_q     <= '0;
            flush_q     <= 1'b0;
            ch_q        <= '0;
            dac_we_q    <= 1'b0;
            dac_data_q  <= '0;
            frame_cnt_q <= '0;
            timeout_q   <= 1'b0;
            wait_cnt_q  <= '0;
            seq_busy_q  <= 1'b0;
`ifdef DAC_SEQ_INIT_EN
            is_init_q   <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            for (int i = 0; i < 4; i++) shadow_q[i] <= shadow_d[i];
            dirty_q     <= dirty_d;
            flush_q     <= flush_d;
            ch_q        <= ch_d;
            dac_we_q    <= dac_we_d;
            dac_data_q  <= dac_data_d;
            frame_cnt_q <= frame_cnt_d;
            timeout_q   <= timeout_d;
            wait_cnt_q  <= wait_cnt_d;
            seq_busy_q  <= seq_busy_d;
`ifdef DAC_SEQ_INIT_EN
            is_init_q   <= is_init_d;
`endif
        end
    end

    // Strobe is masked while RST is high so a pending pulse never reaches the driver.
    assign dac.DAC_WE   = dac_we_q & ~RST;
    assign dac.DAC_DATA = dac_data_q;
    assign SEQ_BUSY     = seq_busy_q;
    assign DIRTY        = dirty_q;
    assign FRAME_CNT    = frame_cnt_q;
    assign TIMEOUT_ERR  = timeout_q;

endmodule

// File: tb/tb_dac_frame_sequencer.sv
module tb_dac_frame_sequencer;

    localparam int BusyTimeout = 255;
    localparam int BusyLen     = 20;

    logic        clk;
    logic        rst;
    logic        ch_we;
    logic [1:0]  ch_addr;
    logic [15:0] ch_data;
    logic        update;
    logic        auto_update;
    logic        refresh_all;
    logic        seq_busy;
    logic [3:0]  dirty;
    logic [15:0] frame_cnt;
    logic        timeout_err;

    int          checks;
    int          errors;
    int          exp_cnt;
    bit          drv_dead;
    bit          prev_we;
    logic [31:0] sb [$];
    logic [31:0] exp_frame;

    dac_frame_sequencer_if dac_if ();

    dac_frame_sequencer dut (
        .CLK_50M     (clk),
        .RST         (rst),
        .CH_WE       (ch_we),
        .CH_ADDR     (ch_addr),
        .CH_DATA     (ch_data),
        .UPDATE      (update),
        .AUTO_UPDATE (auto_update),
        .REFRESH_ALL (refresh_all),
        .dac         (dac_if.master),
        .SEQ_BUSY    (seq_busy),
        .DIRTY       (dirty),
        .FRAME_CNT   (frame_cnt),
        .TIMEOUT_ERR (timeout_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] fmt(input logic [1:0] ch, input logic [15:0] v);
        return {4'h0, 4'h3, 2'b00, ch, v, 4'h0};
    endfunction

    // Driver model: samples DAC_WE, raises DAC_BUSY one clock later, holds it BusyLen clocks.
    initial begin
        dac_if.DAC_BUSY = 1'b0;
        forever begin
            @(negedge clk);
            if (dac_if.DAC_WE === 1'b1 && !drv_dead) begin
                @(posedge clk);
                @(posedge clk);
                #1 dac_if.DAC_BUSY = 1'b1;
                repeat (BusyLen) @(posedge clk);
                #1 dac_if.DAC_BUSY = 1'b0;
            end
        end
    end

    // Scoreboard monitor: every strobe pops one expected frame.
    initial begin
        prev_we = 1'b0;
        forever begin
            @(negedge clk);
            if (dac_if.DAC_WE === 1'b1) begin
                checks++;
                if (prev_we) begin
                    errors++;
                    $display("FAIL we_consecutive: DAC_WE high two cycles at %0t", $time);
                end
                checks++;
                if (dac_if.DAC_BUSY !== 1'b0) begin
                    errors++;
                    $display("FAIL we_while_busy: DAC_BUSY=%b required 0", dac_if.DAC_BUSY);
                end
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_frame: got %h with nothing expected",
                             dac_if.DAC_DATA);
                end else begin
                    exp_frame = sb.pop_front();
                    if (dac_if.DAC_DATA !== exp_frame) begin
                        errors++;
                        $display("FAIL frame_data: got %h required %h", dac_if.DAC_DATA,
                                 exp_frame);
                    end
                end
            end
            prev_we = (dac_if.DAC_WE === 1'b1);
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic wait_idle(input int budget);
        int n;
        n = 0;
        while ((sb.size() != 0 || seq_busy !== 1'b0 || dac_if.DAC_BUSY !== 1'b0)
               && n < budget) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n >= budget) begin
            errors++;
            $display("FAIL wait_idle: pending=%0d seq_busy=%b dac_busy=%b after %0d cycles",
                     sb.size(), seq_busy, dac_if.DAC_BUSY, n);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (dac_if.DAC_WE !== 1'b0) begin errors++; $display("FAIL rst_we: got %b required 0", dac_if.DAC_WE); end
        checks++;
        if (dac_if.DAC_DATA !== 32'd0) begin errors++; $display("FAIL rst_data: got %h required 0", dac_if.DAC_DATA); end
        checks++;
        if (seq_busy !== 1'b0) begin errors++; $display("FAIL rst_seq_busy: got %b required 0", seq_busy); end
        checks++;
        if (dirty !== 4'h0) begin errors++; $display("FAIL rst_dirty: got %h required 0", dirty); end
        checks++;
        if (frame_cnt !== 16'd0) begin errors++; $display("FAIL rst_cnt: got %0d required 0", frame_cnt); end
        checks++;
        if (timeout_err !== 1'b0) begin errors++; $display("FAIL rst_timeout: got %b required 0", timeout_err); end
        rst = 1'b0;
        exp_cnt = 0;
        @(negedge clk);
    endtask

    task automatic test_single();
        sb.push_back(32'h032A_BCD0);
        exp_cnt++;
        ch_we = 1'b1; ch_addr = 2'd2; ch_data = 16'hABCD;
        @(negedge clk);
        ch_we = 1'b0;
        checks++;
        if (dirty !== 4'b0100) begin errors++; $display("FAIL single_dirty_set: got %b required 0100", dirty); end
        update = 1'b1;
        @(negedge clk);
        update = 1'b0;
        checks++;
        if (dac_if.DAC_WE !== 1'b0) begin errors++; $display("FAIL single_lat1: we=%b required 0", dac_if.DAC_WE); end
        @(negedge clk);
        checks++;
        if (dac_if.DAC_WE !== 1'b0) begin errors++; $display("FAIL single_lat2: we=%b required 0", dac_if.DAC_WE); end
        @(negedge clk);
        checks++;
        if (dac_if.DAC_WE !== 1'b1) begin errors++; $display("FAIL single_lat3: we=%b required 1", dac_if.DAC_WE); end
        wait_idle(500);
        checks++;
        if (dirty !== 4'h0) begin errors++; $display("FAIL single_dirty: got %b required 0", dirty); end
        checks++;
        if (frame_cnt !== 16'(exp_cnt)) begin errors++; $display("FAIL single_cnt: got %0d required %0d", frame_cnt, exp_cnt); end
    endtask

    task automatic test_flush_all();
        for (int i = 0; i < 4; i++) begin
            ch_we = 1'b1; ch_addr = 2'(i); ch_data = 16'(i + 1);
            @(negedge clk);
        end
        ch_we = 1'b0;
        refresh_all = 1'b1;
        @(negedge clk);
        refresh_all = 1'b0;
        checks++;
        if (dirty !== 4'hF) begin errors++; $display("FAIL flush_dirty_all: got %b required 1111", dirty); end
        for (int i = 0; i < 4; i++) begin
            sb.push_back(fmt(2'(i), 16'(i + 1)));
            exp_cnt++;
        end
        update = 1'b1;
        @(negedge clk);
        update = 1'b0;
        wait_idle(1000);
        checks++;
        if (frame_cnt !== 16'(exp_cnt)) begin errors++; $display("FAIL flush_cnt: got %0d required %0d", frame_cnt, exp_cnt); end
        checks++;
        if (dirty !== 4'h0) begin errors++; $display("FAIL flush_dirty: got %b required 0", dirty); end
    endtask

    task automatic test_auto_update();
        int cnt_before;
        auto_update = 1'b1;
        sb.push_back(fmt(2'd1, 16'h5555));
        exp_cnt++;
        ch_we = 1'b1; ch_addr = 2'd1; ch_data = 16'h5555;
        @(negedge clk);
        ch_we = 1'b0;
        wait_idle(500);
        checks++;
        if (frame_cnt !== 16'(exp_cnt)) begin errors++; $display("FAIL auto_cnt: got %0d required %0d", frame_cnt, exp_cnt); end
        auto_update = 1'b0;
        @(negedge clk);
        cnt_before = exp_cnt;
        ch_we = 1'b1; ch_addr = 2'd1; ch_data = 16'h1234;
        @(negedge clk);
        ch_we = 1'b0;
        repeat (1000) @(negedge clk);
        checks++;
        if (dirty !== 4'b0010) begin errors++; $display("FAIL manual_dirty: got %b required 0010", dirty); end
        checks++;
        if (frame_cnt !== 16'(cnt_before)) begin errors++; $display("FAIL manual_cnt: got %0d required %0d", frame_cnt, cnt_before); end
        checks++;
        if (seq_busy !== 1'b0) begin errors++; $display("FAIL manual_seq_busy: got %b required 0", seq_busy); end
        sb.push_back(fmt(2'd1, 16'h1234));
        exp_cnt++;
        update = 1'b1;
        @(negedge clk);
        update = 1'b0;
        wait_idle(500);
    endtask

    task automatic test_collision();
        sb.push_back(fmt(2'd0, 16'hAAAA));
        sb.push_back(fmt(2'd0, 16'hBBBB));
        exp_cnt += 2;
        ch_we = 1'b1; ch_addr = 2'd0; ch_data = 16'hAAAA;
        @(negedge clk);
        ch_we = 1'b0;
        update = 1'b1;
        @(negedge clk);
        update = 1'b0;
        @(negedge clk);
        // Sequencer is in ISSUE during this cycle.
        ch_we = 1'b1; ch_addr = 2'd0; ch_data = 16'hBBBB;
        @(negedge clk);
        ch_we = 1'b0;
        checks++;
        if (dac_if.DAC_WE !== 1'b1) begin errors++; $display("FAIL coll_we: got %b required 1", dac_if.DAC_WE); end
        checks++;
        if (dirty[0] !== 1'b1) begin errors++; $display("FAIL coll_dirty: got %b required 1", dirty[0]); end
        wait_idle(1000);
        checks++;
        if (dirty !== 4'h0) begin errors++; $display("FAIL coll_dirty_end: got %b required 0", dirty); end
        checks++;
        if (frame_cnt !== 16'(exp_cnt)) begin errors++; $display("FAIL coll_cnt: got %0d required %0d", frame_cnt, exp_cnt); end
    endtask

    task automatic test_timeout();
        bit seen;
        drv_dead = 1'b1;
        sb.push_back(fmt(2'd3, 16'h0F0F));
        exp_cnt++;
        ch_we = 1'b1; ch_addr = 2'd3; ch_data = 16'h0F0F; update = 1'b1;
        @(negedge clk);
        ch_we = 1'b0; update = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            if (dac_if.DAC_WE === 1'b1) seen = 1'b1;
            else @(negedge clk);
        end
        checks++;
        if (!seen) begin errors++; $display("FAIL to_strobe: got no DAC_WE required one"); end
        repeat (BusyTimeout - 10) @(negedge clk);
        checks++;
        if (timeout_err !== 1'b0) begin errors++; $display("FAIL to_early: got %b required 0", timeout_err); end
        checks++;
        if (seq_busy !== 1'b1) begin errors++; $display("FAIL to_waiting: seq_busy=%b required 1", seq_busy); end
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            if (timeout_err === 1'b1) seen = 1'b1;
            else @(negedge clk);
        end
        checks++;
        if (!seen) begin errors++; $display("FAIL to_set: got %b required 1", timeout_err); end
        repeat (3) @(negedge clk);
        checks++;
        if (seq_busy !== 1'b0) begin errors++; $display("FAIL to_idle: seq_busy=%b required 0", seq_busy); end
        checks++;
        if (dirty !== 4'h0) begin errors++; $display("FAIL to_dirty: got %b required 0", dirty); end
        drv_dead = 1'b0;
        sb.push_back(fmt(2'd0, 16'h0007));
        exp_cnt++;
        ch_we = 1'b1; ch_addr = 2'd0; ch_data = 16'h0007; update = 1'b1;
        @(negedge clk);
        ch_we = 1'b0; update = 1'b0;
        wait_idle(500);
        checks++;
        if (timeout_err !== 1'b1) begin errors++; $display("FAIL to_sticky: got %b required 1", timeout_err); end
        checks++;
        if (frame_cnt !== 16'(exp_cnt)) begin errors++; $display("FAIL to_cnt: got %0d required %0d", frame_cnt, exp_cnt); end
    endtask

    task automatic test_reset_midframe();
        bit seen;
        sb.push_back(fmt(2'd1, 16'h2222));
        exp_cnt++;
        ch_we = 1'b1; ch_addr = 2'd1; ch_data = 16'h2222; update = 1'b1;
        @(negedge clk);
        ch_we = 1'b0; update = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            if (dac_if.DAC_BUSY === 1'b1) seen = 1'b1;
            else @(negedge clk);
        end
        checks++;
        if (!seen) begin errors++; $display("FAIL mid_busy: DAC_BUSY never rose"); end
        // Dirty a channel while in WAIT_LO so reset has something to clear.
        ch_we = 1'b1; ch_addr = 2'd2; ch_data = 16'h9999;
        @(negedge clk);
        ch_we = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if (dac_if.DAC_WE !== 1'b0) begin errors++; $display("FAIL mid_we: got %b required 0", dac_if.DAC_WE); end
        checks++;
        if (dac_if.DAC_DATA !== 32'd0) begin errors++; $display("FAIL mid_data: got %h required 0", dac_if.DAC_DATA); end
        checks++;
        if (seq_busy !== 1'b0) begin errors++; $display("FAIL mid_seq_busy: got %b required 0", seq_busy); end
        checks++;
        if (dirty !== 4'h0) begin errors++; $display("FAIL mid_dirty: got %b required 0", dirty); end
        checks++;
        if (frame_cnt !== 16'd0) begin errors++; $display("FAIL mid_cnt: got %0d required 0", frame_cnt); end
        checks++;
        if (timeout_err !== 1'b0) begin errors++; $display("FAIL mid_timeout: got %b required 0", timeout_err); end
        rst = 1'b0;
        exp_cnt = 0;
        wait_idle(500);
        // Shadows must be back at zero after reset.
        for (int i = 0; i < 4; i++) begin
            sb.push_back(fmt(2'(i), 16'h0000));
            exp_cnt++;
        end
        refresh_all = 1'b1; update = 1'b1;
        @(negedge clk);
        refresh_all = 1'b0; update = 1'b0;
        wait_idle(1000);
        checks++;
        if (frame_cnt !== 16'(exp_cnt)) begin errors++; $display("FAIL post_rst_cnt: got %0d required %0d", frame_cnt, exp_cnt); end
        checks++;
        if (dirty !== 4'h0) begin errors++; $display("FAIL post_rst_dirty: got %b required 0", dirty); end
    endtask

    initial begin
        checks      = 0;
        errors      = 0;
        exp_cnt     = 0;
        drv_dead    = 1'b0;
        rst         = 1'b1;
        ch_we       = 1'b0;
        ch_addr     = 2'd0;
        ch_data     = 16'd0;
        update      = 1'b0;
        auto_update = 1'b0;
        refresh_all = 1'b0;

        test_reset();
        test_single();
        test_flush_all();
        test_auto_update();
        test_collision();
        test_timeout();
        test_reset_midframe();

        checks++;
        if (sb.size() != 0) begin errors++; $display("FAIL sb_drain: %0d frames still expected, required 0", sb.size()); end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
